// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// Accepts a byte only while idle; the line, active and done flags are all registered.
`timescale 1ns/1ps
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state,   state_n;
    logic [CNT_W-1:0] cnt,     cnt_n;
    logic [2:0]       idx,     idx_n;
    logic [7:0]       tx_data, tx_data_n;
    logic             serial_n;
    logic             active_n;
    logic             done_n;

    logic             bit_end;
    logic [2:0]       idx_inc;

    assign bit_end = (cnt == CNT_MAX);
    assign idx_inc = idx + 3'd1;

    // State and output registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            tx_data     <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            tx_data     <= tx_data_n;
            o_TX_Serial <= serial_n;
            o_TX_Active <= active_n;
            o_TX_Done   <= done_n;
        end
    end

    // Next-state and next-output logic; done is a single-cycle pulse by default
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        tx_data_n = tx_data;
        serial_n  = o_TX_Serial;
        active_n  = o_TX_Active;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                serial_n = 1'b1;
                if (i_TX_DV) begin
                    tx_data_n = i_TX_Byte;
                    serial_n  = 1'b0;
                    active_n  = 1'b1;
                    cnt_n     = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n    = '0;
                    serial_n = tx_data[0];
                    idx_n    = '0;
                    state_n  = DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx != 3'd7) begin
                        idx_n    = idx_inc;
                        serial_n = tx_data[idx_inc];
                    end else begin
                        serial_n = 1'b1;
                        state_n  = STOP;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    active_n = 1'b0;
                    done_n   = 1'b1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line monitor decodes every frame, checks exact bit timing and
// compares the decoded byte against a scoreboard queue filled when stimulus is driven.
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       dv;
    logic       use4;
    logic [7:0] tx_byte;
    logic       ser_a, act_a, done_a;
    logic       ser_b, act_b, done_b;
    logic       dv_a, dv_b;

    logic       m_ser, m_act, m_done;
    int         m_cpb;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int last_done = 0;
    int last_start = 0;
    int prev_start = 0;

    logic [7:0] q[$];

    assign dv_a   = dv & ~use4;
    assign dv_b   = dv & use4;
    assign m_ser  = use4 ? ser_b  : ser_a;
    assign m_act  = use4 ? act_b  : act_a;
    assign m_done = use4 ? done_b : done_a;
    assign m_cpb  = use4 ? 4 : 217;

    uart_tx u_dut_a (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_TX_DV     (dv_a),
        .i_TX_Byte   (tx_byte),
        .o_TX_Serial (ser_a),
        .o_TX_Active (act_a),
        .o_TX_Done   (done_a)
    );

    uart_tx #(.CLKS_PER_BIT(4)) u_dut_b (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_TX_DV     (dv_b),
        .i_TX_Byte   (tx_byte),
        .o_TX_Serial (ser_b),
        .o_TX_Active (act_b),
        .o_TX_Done   (done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_done === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            last_done <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic fr_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return b[n-1];
    endfunction

    // Line monitor: frame bit n must hold for exactly m_cpb samples
    initial begin : mon
        logic       prev;
        logic       has_exp;
        logic       aborted;
        logic [7:0] exp_b;
        logic [7:0] got;
        int         errs;
        int         n;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
                continue;
            end
            if (prev === 1'b1 && m_ser === 1'b0) begin
                n          = 10 * m_cpb;
                prev_start = last_start;
                last_start = cyc;
                errs       = 0;
                aborted    = 1'b0;
                got        = '0;
                exp_b      = '0;
                has_exp    = 1'b0;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start at cycle %0d, expected no frame", cyc);
                end else begin
                    exp_b   = q.pop_front();
                    has_exp = 1'b1;
                end
                if (m_act !== 1'b1) errs++;
                for (int j = 1; j < n; j++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (m_ser !== fr_bit(exp_b, j / m_cpb)) errs++;
                    if (m_act !== 1'b1) errs++;
                    if (m_done !== 1'b0) errs++;
                    if (j >= m_cpb && j < 9 * m_cpb && (j % m_cpb) == m_cpb / 2)
                        got[j / m_cpb - 1] = m_ser;
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else if (m_done !== 1'b1 || m_act !== 1'b0 || m_ser !== 1'b1) errs++;
                end
                if (!aborted && has_exp) begin
                    check("frame_line_errors", 32'(errs), 32'd0);
                    check("rx_byte", {24'd0, got}, {24'd0, exp_b});
                end
                prev = m_ser;
            end else begin
                prev = m_ser;
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       sel4;
        int         exp_len;
    } vec_t;

    vec_t vecs[6];
    int   k;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        dv      = 1'b1;
        tx_byte = b;
        q.push_back(b);
        tick();
        k       = cyc;
        dv      = 1'b0;
        tx_byte = ~b;
    endtask

    task automatic pulse_at(input int e, input logic [7:0] b);
        while (cyc < e - 1) tick();
        dv      = 1'b1;
        tx_byte = b;
        tick();
        dv      = 1'b0;
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0;
        int lows;
        clk     = 1'b0;
        rst_n   = 1'b0;
        dv      = 1'b0;
        use4    = 1'b0;
        tx_byte = '0;

        #12;
        check("reset_outputs", {26'd0, ser_a, act_a, done_a, ser_b, act_b, done_b},
              {26'd0, 6'b100100});
        tick();
        rst_n = 1'b1;

        vecs[0] = '{8'h37, 1'b0, 2170};
        vecs[1] = '{8'h5A, 1'b1, 40};
        vecs[2] = '{8'h00, 1'b1, 40};
        vecs[3] = '{8'hFF, 1'b1, 40};
        vecs[4] = '{8'h81, 1'b1, 40};
        vecs[5] = '{8'hA5, 1'b1, 40};

        foreach (vecs[i]) begin
            use4 = vecs[i].sel4;
            d0   = done_cnt;
            send(vecs[i].data);
            repeat (vecs[i].exp_len + 5) tick();
            check("frame_len", 32'(last_done - last_start), 32'(vecs[i].exp_len));
            check("done_count", 32'(done_cnt - d0), 32'd1);
            check("q_drained", 32'(q.size()), 32'd0);
        end

        // Requests while busy, including on the STOP exit edge, are dropped
        use4 = 1'b0;
        d0   = done_cnt;
        send(8'hA5);
        d0 = d0;
        begin
            int kb;
            kb = k;
            pulse_at(kb + 100, 8'h3C);
            pulse_at(kb + 2170, 8'h3C);
            while (cyc < kb + 2200) tick();
        end
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (ser_a !== 1'b1) lows++;
        end
        check("busy_idle_high", 32'(lows), 32'd0);
        check("busy_done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_q_drained", 32'(q.size()), 32'd0);

        // Back-to-back frames with DV held high
        d0 = done_cnt;
        tick();
        dv      = 1'b1;
        tx_byte = 8'h00;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        tick();
        k       = cyc;
        tx_byte = 8'hFF;
        while (cyc < k + 2170) tick();
        check("b2b_gap_active_low", {31'd0, act_a}, 32'd0);
        tick();
        check("b2b_gap_active_high", {31'd0, act_a}, 32'd1);
        dv      = 1'b0;
        tx_byte = 8'h11;
        while (cyc < k + 2171 + 2200) tick();
        check("b2b_start_spacing", 32'(last_start - prev_start), 32'd2171);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_q_drained", 32'(q.size()), 32'd0);

        // Reset during data bit 3 of 0x81
        d0 = done_cnt;
        send(8'h81);
        while (cyc < k + 4 * 217 + 100) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {29'd0, ser_a, act_a, done_a}, {29'd0, 3'b100});
        repeat (3) tick();
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        rst_n   = 1'b1;
        dv      = 1'b1;
        tx_byte = 8'h81;
        q.push_back(8'h81);
        tick();
        k  = cyc;
        dv = 1'b0;
        while (cyc < k + 2200) tick();
        check("rst_restart_start", 32'(last_start), 32'(k));
        check("rst_done_count", 32'(done_cnt - d0), 32'd1);
        check("rst_q_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
